// File: rtl/req_latch_db.sv
// req_latch_db: four-channel sync + debounce front-end producing sticky
// pending-request bits for the priority encoder, cleared by indexed ack.
//
// Ports:
//   clk          single clock for all state
//   rst_n        asynchronous active-low reset (release synchronous to clk)
//   btn_in[3:0]  raw asynchronous button/switch lines, active-high
//   req[3:0]     pending requests, feeds encoder request input
//   valid        |req
//   db_level[3:0] debounced levels for status LEDs
//   ack          consumer serviced one request this cycle
//   ack_idx[1:0] index of serviced request, used only when ack=1
//
// Build option: DEBOUNCE_BYPASS_EN replaces the debounce counters with a
// plain one-cycle register (glitches pass through; for sim/bring-up).
module req_latch_db #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_in,
  output logic [3:0] req,
  output logic       valid,
  output logic [3:0] db_level,
  input  logic       ack,
  input  logic [1:0] ack_idx
);

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_stable;
  logic [3:0] r_req;
  logic [3:0] w_stable_nxt;
  logic [3:0] w_rise;
  logic [3:0] w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN

  always_comb begin
    w_stable_nxt = r_sync2;
  end

`else

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] w_cnt_nxt [4];

  // A change is accepted only after DB_CYCLES consecutive differing
  // samples; any sample matching the stable level restarts the count.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_stable_nxt[i] = r_stable[i];
      w_cnt_nxt[i]    = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == LP_MAX) begin
          w_stable_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
    end else begin
      r_stable <= w_stable_nxt;
    end
  end

  assign w_rise = w_stable_nxt & ~r_stable;
  assign w_clr  = ack ? (4'b0001 << ack_idx) : 4'b0000;

  // A new press on the same edge as its ack wins, so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
    end else begin
      r_req <= w_rise | (r_req & ~w_clr);
    end
  end

  assign req      = r_req;
  assign valid    = |r_req;
  assign db_level = r_stable;

endmodule

// File: tb/tb_req_latch_db.sv
// Testbench for req_latch_db: random + directed stimulus, reference model
// built on input-sample history, scoreboard queue checked at negedge.
module tb_req_latch_db;

  localparam int DB = 4;
`ifdef DEBOUNCE_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = DB + 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] req;
  logic       valid;
  logic [3:0] db_level;
  logic       ack;
  logic [1:0] ack_idx;

  int n_chk = 0;
  int n_err = 0;

  req_latch_db #(
    .DB_CYCLES(DB),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .req(req),
    .valid(valid),
    .db_level(db_level),
    .ack(ack),
    .ack_idx(ack_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: stable level of a channel flips to v once the last
  // DB synchronised samples (btn delayed two edges) all equal v.
  logic [3:0] hist[$];
  logic [3:0] m_st;
  logic [3:0] m_rq;
  logic [3:0] expq[$];
  logic [3:0] expd[$];
  logic [3:0] m_nst;
  logic [3:0] m_clr;
  logic [3:0] m_s;
  logic       m_all;
  int         m_n;

  function automatic logic [3:0] samp(input int j);
    if (j < 0) return 4'b0000;
    return hist[j];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      m_st = '0;
      m_rq = '0;
    end else begin
      hist.push_back(btn_in);
      m_n   = hist.size();
      m_nst = m_st;
      for (int i = 0; i < 4; i++) begin
`ifdef DEBOUNCE_BYPASS_EN
        m_s = samp(m_n - 3);
        m_nst[i] = m_s[i];
`else
        m_all = 1'b1;
        for (int k = 0; k < DB; k++) begin
          m_s = samp(m_n - 3 - k);
          if (m_s[i] == m_st[i]) m_all = 1'b0;
        end
        if (m_all) m_nst[i] = ~m_st[i];
`endif
      end
      m_clr = '0;
      if (ack) m_clr[ack_idx] = 1'b1;
      m_rq = (m_nst & ~m_st) | (m_rq & ~m_clr);
      m_st = m_nst;
    end
    expq.push_back(m_rq);
    expd.push_back(m_st);
  end

  logic [3:0] e_rq;
  logic [3:0] e_db;

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e_rq = expq.pop_front();
      e_db = expd.pop_front();
      chk("req", int'(req), int'(e_rq));
      chk("valid", int'(valid), int'(e_rq != 4'b0000));
      chk("db_level", int'(db_level), int'(e_db));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack(input logic [1:0] idx);
    ack     = 1'b1;
    ack_idx = idx;
    cyc(1);
    ack     = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_in  = '0;
    ack     = 1'b0;
    ack_idx = '0;
    #1;
    chk("reset_req", int'(req), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_db", int'(db_level), 0);
    cyc(3);
    rst_n = 1'b1;

    // single press then ack
    btn_in = 4'b0010;
    cyc(LAT - 1);
    chk("press_early", int'(req), 0);
    cyc(1);
    chk("press_lat", int'(req), 4'b0010);
    cyc(3);
    do_ack(2'd1);
    cyc(2);

    // glitch on channel 3
    btn_in = 4'b1010;
    cyc(3);
    btn_in = 4'b0010;
    cyc(DB + 4);

    // set and clear on the same edge
    do_ack(2'd1);
    btn_in = 4'b0001;
    cyc(LAT + 2);
    btn_in = 4'b0000;
    cyc(LAT + 2);
    btn_in = 4'b0001;
    cyc(LAT - 1);
    chk("pre_rise_req0", int'(req[0]), 1);
    chk("pre_rise_db0", int'(db_level[0]), 0);
    do_ack(2'd0);
    chk("setwin_req0", int'(req[0]), 1);
    chk("setwin_db0", int'(db_level[0]), 1);
    do_ack(2'd0);
    cyc(1);

    // two pending, independent clear, ack of non-pending bit
    btn_in = 4'b1010;
    cyc(LAT + 2);
    do_ack(2'd3);
    chk("ack3", int'(req), 4'b0010);
    do_ack(2'd2);
    chk("ack2_noop", int'(req), 4'b0010);
    do_ack(2'd1);
    btn_in = 4'b0000;
    cyc(LAT + 2);

    // reset during the debounce count
    btn_in = 4'b0100;
    cyc(4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", int'(req), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_db", int'(db_level), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(LAT - 1);
    chk("post_rst_early", int'(req[2]), 0);
    cyc(1);
    chk("post_rst_lat", int'(req[2]), 1);
    do_ack(2'd2);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) btn_in[i] = ~btn_in[i];
      end
      ack     = ($urandom_range(2) == 0);
      ack_idx = 2'($urandom_range(3));
      cyc(1);
    end
    ack = 1'b0;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
